// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative array multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Width of the row counter; one bit minimum so WIDTH=2 still has a counter.
    function automatic int cnt_width(input int width);
        if (width <= 2) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/seq_array_multiplier_row.sv
// One row of an unsigned array multiplier: partial sum plus gated multiplicand.
module array_mult_row
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic             b_bit,
    input  logic [WIDTH-1:0] s_in,
    output logic [WIDTH:0]   s_out
);

    logic [WIDTH-1:0] gated_s;

    // Gate the multiplicand by the current multiplier bit and add with carry-out kept.
    always_comb begin
        gated_s = a & {WIDTH{b_bit}};
        s_out   = {1'b0, s_in} + {1'b0, gated_s};
    end

endmodule

// File: rtl/seq_array_multiplier.sv
// Iterative WIDTH x WIDTH unsigned multiplier: one array row per clock,
// product returned with a one-cycle done pulse.
module seq_array_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Architectural state. The accumulator holds the shifted partial sum; the
    // row carry-out lands in its MSB after each shift, so WIDTH bits suffice.
    mult_state_t        state_r, state_s;
    logic [WIDTH-1:0]   a_r, a_s;
    logic [WIDTH-1:0]   b_r, b_s;
    logic [WIDTH-1:0]   acc_r, acc_s;
    logic [WIDTH-1:0]   lo_r, lo_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [2*WIDTH-1:0] p_r, p_s;

    logic [WIDTH:0]     row_sum_s;

    array_mult_row #(
        .WIDTH (WIDTH)
    ) u_row (
        .a     (a_r),
        .b_bit (b_r[cnt_r]),
        .s_in  (acc_r),
        .s_out (row_sum_s)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        acc_s   = acc_r;
        lo_s    = lo_r;
        cnt_s   = cnt_r;
        p_s     = p_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    a_s     = A;
                    b_s     = B;
                    acc_s   = {WIDTH{1'b0}};
                    lo_s    = {WIDTH{1'b0}};
                    cnt_s   = CNT_ZERO;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                acc_s = row_sum_s[WIDTH:1];
                lo_s  = {row_sum_s[0], lo_r[WIDTH-1:1]};
                cnt_s = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    // Final row: publish the product on the DONE-entry edge.
                    state_s = DONE;
                    p_s     = {row_sum_s[WIDTH:1], row_sum_s[0], lo_r[WIDTH-1:1]};
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
        done_s = (state_s == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            p_r     <= {(2*WIDTH){1'b0}};
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            acc_r   <= acc_s;
            lo_r    <= lo_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            p_r     <= p_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign P    = p_r;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed, table-driven bench for seq_array_multiplier (WIDTH=8).
module tb_seq_array_multiplier;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*W-1:0] P;

    int checks;
    int failures;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [12];

    seq_array_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Accept one operand pair and verify the done timing and product.
    task automatic run_vec(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int early;
        early = 0;
        A = a;
        B = b;
        start = 1'b1;
        tick();                      // edge n: accept
        start = 1'b0;
        A = ~a;                      // post-accept operand changes must not matter
        B = ~b;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (done) early++;
        end
        check("no_early_done", early, 0);
        tick();                      // edge n+8
        check("done_at_n8", {31'd0, done}, 32'd1);
        check("product", {16'd0, P}, {16'd0, exp});
        tick();                      // edge n+9
        check("done_pulse_one_cycle", {31'd0, done}, 32'd0);
        check("idle_after_done", {31'd0, busy}, 32'd0);
        check("product_held", {16'd0, P}, {16'd0, exp});
    endtask

    initial begin
        int cnt_done;
        int cyc;
        int last_cyc;
        int idx;
        int n_pairs;
        logic [15:0] held;
        logic [7:0]  cur_a;
        logic [7:0]  cur_b;

        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;

        vecs[0]  = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01};
        vecs[1]  = '{a: 8'h00, b: 8'hA5, p: 16'h0000};
        vecs[2]  = '{a: 8'h80, b: 8'h02, p: 16'h0100};
        vecs[3]  = '{a: 8'h01, b: 8'h01, p: 16'h0001};
        vecs[4]  = '{a: 8'h0F, b: 8'h0F, p: 16'h00E1};
        vecs[5]  = '{a: 8'hC8, b: 8'h7B, p: 16'h6018};
        vecs[6]  = '{a: 8'h12, b: 8'h34, p: 16'h03A8};
        vecs[7]  = '{a: 8'hFF, b: 8'h01, p: 16'h00FF};
        vecs[8]  = '{a: 8'h01, b: 8'h80, p: 16'h0080};
        vecs[9]  = '{a: 8'hAA, b: 8'h55, p: 16'h3872};
        vecs[10] = '{a: 8'h80, b: 8'h80, p: 16'h4000};
        vecs[11] = '{a: 8'h03, b: 8'h05, p: 16'h000F};

        // Reset held for two cycles, then idle.
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_p", {16'd0, P}, 32'd0);
        cnt_done = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || busy) cnt_done++;
        end
        check("idle_no_activity", cnt_done, 0);

        // Table-driven products.
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // Start pulses while busy are ignored.
        A = 8'h0F;
        B = 8'h0F;
        start = 1'b1;
        tick();                      // edge n
        start = 1'b0;
        A = 8'hFF;
        B = 8'hFF;
        cnt_done = 0;
        for (int k = 1; k <= 10; k++) begin
            start = (k == 3 || k == 8) ? 1'b1 : 1'b0;
            tick();
            if (done) cnt_done++;
            if (k == 8) begin
                check("busy_start_done", {31'd0, done}, 32'd1);
                check("busy_start_p", {16'd0, P}, 32'h000000E1);
            end
            if (k == 9 || k == 10) begin
                check("busy_start_idle", {31'd0, busy}, 32'd0);
            end
        end
        start = 1'b0;
        check("busy_start_single_done", cnt_done, 1);

        // Reset mid-operation discards the work.
        A = 8'hC8;
        B = 8'h7B;
        start = 1'b1;
        tick();                      // edge n
        start = 1'b0;
        tick();
        tick();
        tick();                      // edge n+3
        rst = 1'b1;
        tick();                      // edge n+4
        rst = 1'b0;
        check("midrst_p", {16'd0, P}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        cnt_done = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) cnt_done++;
        end
        check("midrst_no_done", cnt_done, 0);
        run_vec(8'h03, 8'h05, 16'h000F);

        // Reset wins over start on the same edge.
        A = 8'h11;
        B = 8'h11;
        start = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("rst_priority_busy", {31'd0, busy}, 32'd0);
        check("rst_priority_p", {16'd0, P}, 32'd0);

        // Back-to-back with start held high; next pair applied after each done.
        n_pairs  = 300;
        idx      = 0;
        cyc      = 0;
        last_cyc = 0;
        held     = 16'h0000;
        cur_a    = 8'hFF;
        cur_b    = 8'hFF;
        A        = cur_a;
        B        = cur_b;
        start    = 1'b1;
        for (int t = 0; t < n_pairs * 10 + 40; t++) begin
            tick();
            cyc++;
            if (done) begin
                check("b2b_product", {16'd0, P}, {16'd0, 16'(cur_a) * 16'(cur_b)});
                if (idx > 0) begin
                    check("b2b_spacing", cyc - last_cyc, 10);
                end
                last_cyc = cyc;
                held = 16'(cur_a) * 16'(cur_b);
                idx++;
                if (idx == n_pairs) break;
                if (idx == 1) begin
                    cur_a = 8'h00;
                    cur_b = 8'h00;
                end else begin
                    cur_a = 8'((idx * 97 + 13) & 255);
                    cur_b = 8'((idx * 53 + 7) & 255);
                end
                A = cur_a;
                B = cur_b;
            end else if (idx > 0) begin
                check("b2b_p_stable", {16'd0, P}, {16'd0, held});
            end
        end
        start = 1'b0;
        check("b2b_all_pairs_done", idx, n_pairs);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
